// File: rtl/mipi_rx_pkg.sv
// Shared constants and FSM encodings for the MIPI RX lane aligner.
package mipi_rx_pkg;
  localparam int LANE_W        = 8;
  localparam int DEF_NUM_LANES = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ALIGN  = 2'd1;
  localparam state_t ST_STREAM = 2'd2;
  localparam state_t ST_FLUSH  = 2'd3;
endpackage

// File: rtl/lane_skew_fifo.sv
// Generic small FIFO: write/read/clear, combinational head read.
// Latency 1 cycle write-to-readable; write to full is dropped unless a read frees the slot that cycle.
module lane_skew_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  // The MSB is a lap bit so full and empty stay distinct for any depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p[IDX_W-1:0] == LAST) return {~p[PTR_W-1], {IDX_W{1'b0}}};
    return p + PTR_W'(1);
  endfunction

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                  (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign do_rd  = rd_rdy & ~empty;
  assign do_wr  = wr_vld & (~full | do_rd);
  assign rd_dat = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem[wr_ptr[IDX_W-1:0]] <= wr_dat;
  end
endmodule

// File: rtl/mipi_rx_lane_aligner.sv
// Deskews per-lane HS bytes using SoT sync pulses and per-lane skew FIFOs.
// Latency 2 cycles from the latest lane's write; no backpressure, overflow/timeout pulse skew_err_o and flush.
module mipi_rx_lane_aligner
  import mipi_rx_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int MAX_SKEW  = 3
) (
  input  logic                        sync_clk_i,
  input  logic                        sync_rst_i,
  input  logic [LANE_W*NUM_LANES-1:0] hs_rx_data_i,
  input  logic [NUM_LANES-1:0]        hs_rx_data_sync_i,
  input  logic [NUM_LANES-1:0]        hs_rx_valid_i,
  output logic [LANE_W*NUM_LANES-1:0] aligned_data_o,
  output logic                        aligned_valid_o,
  output logic                        aligned_sot_o,
  output logic                        skew_err_o,
  output logic                        busy_o
);
  localparam int DEPTH = MAX_SKEW + 1;
  localparam int CNT_W = $clog2(MAX_SKEW + 2);
  localparam logic [CNT_W-1:0] SKEW_LIM = CNT_W'(MAX_SKEW);

  state_t                      state_q, state_d;
  logic [NUM_LANES-1:0]        armed_q, armed_d, sync_hit, dup_hit;
  logic [NUM_LANES-1:0]        wr_vld, full, empty, ovf;
  logic [CNT_W-1:0]            skew_cnt_q;
  logic [LANE_W*NUM_LANES-1:0] pop_dat, aligned_dat_q;
  logic                        pop_vld, flush, first_q, aligned_vld_q, aligned_sot_q;
  logic                        timeout, burst_end, err;

  assign flush     = (state_q == ST_FLUSH);
  assign wr_vld    = armed_q & hs_rx_valid_i;
  assign pop_vld   = (state_q == ST_STREAM) & ~|empty;
  assign ovf       = wr_vld & full & {NUM_LANES{~pop_vld}};
  assign timeout   = (state_q == ST_ALIGN) && (skew_cnt_q >= SKEW_LIM);
  assign burst_end = (state_q == ST_STREAM) && |(~hs_rx_valid_i & empty);

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    lane_skew_fifo #(
      .WIDTH (LANE_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk    (sync_clk_i),
      .rst    (sync_rst_i),
      .clr    (flush),
      .wr_vld (wr_vld[n]),
      .wr_dat (hs_rx_data_i[n*LANE_W +: LANE_W]),
      .rd_rdy (pop_vld),
      .rd_dat (pop_dat[n*LANE_W +: LANE_W]),
      .full   (full[n]),
      .empty  (empty[n])
    );
  end

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    err      = 1'b0;
    sync_hit = '0;
    dup_hit  = '0;
    if (state_q == ST_IDLE || state_q == ST_ALIGN) sync_hit = hs_rx_data_sync_i & ~armed_q;
    if (state_q == ST_ALIGN) dup_hit = hs_rx_data_sync_i & armed_q;
    case (state_q)
      ST_IDLE: begin
        armed_d = armed_q | sync_hit;
        if (|ovf) begin
          err     = 1'b1;
          state_d = ST_FLUSH;
        end else if (&sync_hit) begin
          state_d = ST_STREAM;
        end else if (|sync_hit) begin
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        armed_d = armed_q | sync_hit;
        if (timeout || |dup_hit || |ovf) begin
          err     = 1'b1;
          state_d = ST_FLUSH;
        end else if (&armed_d) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (|ovf) begin
          err     = 1'b1;
          state_d = ST_FLUSH;
        end else if (burst_end) begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        armed_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sync_clk_i) begin
    if (sync_rst_i) begin
      state_q       <= ST_IDLE;
      armed_q       <= '0;
      skew_cnt_q    <= '0;
      first_q       <= 1'b1;
      aligned_vld_q <= 1'b0;
      aligned_sot_q <= 1'b0;
      aligned_dat_q <= '0;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      skew_cnt_q    <= (state_q == ST_ALIGN) ? skew_cnt_q + CNT_W'(1) : '0;
      // Re-armed outside STREAM so the next burst's first word carries SoT.
      first_q       <= (state_q != ST_STREAM) ? 1'b1 : (first_q & ~pop_vld);
      aligned_vld_q <= pop_vld;
      aligned_sot_q <= pop_vld & first_q;
      if (pop_vld) aligned_dat_q <= pop_dat;
    end
  end

  assign aligned_data_o  = aligned_dat_q;
  assign aligned_valid_o = aligned_vld_q;
  assign aligned_sot_o   = aligned_sot_q;
  assign skew_err_o      = err & ~sync_rst_i;
  assign busy_o          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mipi_rx_lane_aligner.sv
// Scenario bench for mipi_rx_lane_aligner: lane stimulus per relative cycle, expected words queued at drive time.
module tb_mipi_rx_lane_aligner;
  logic        clk = 1'b0;
  logic        sync_rst_i = 1'b1;
  logic [31:0] hs_rx_data_i = '0;
  logic [3:0]  hs_rx_data_sync_i = '0;
  logic [3:0]  hs_rx_valid_i = '0;
  logic [31:0] aligned_data_o;
  logic        aligned_valid_o, aligned_sot_o, skew_err_o, busy_o;

  typedef struct {
    logic [31:0] word;
    int          cyc;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         sync_at[4];
  int         len_at[4];
  int         dup_at, rst_at, err_at;
  bit         expect_words;
  logic [7:0] seed;

  always #5 clk = ~clk;

  mipi_rx_lane_aligner #(.NUM_LANES(4), .MAX_SKEW(3)) dut (
    .sync_clk_i        (clk),
    .sync_rst_i        (sync_rst_i),
    .hs_rx_data_i      (hs_rx_data_i),
    .hs_rx_data_sync_i (hs_rx_data_sync_i),
    .hs_rx_valid_i     (hs_rx_valid_i),
    .aligned_data_o    (aligned_data_o),
    .aligned_valid_o   (aligned_valid_o),
    .aligned_sot_o     (aligned_sot_o),
    .skew_err_o        (skew_err_o),
    .busy_o            (busy_o)
  );

  function automatic logic [7:0] lane_byte(input int n, input int i);
    return seed + 8'(4 * i + n);
  endfunction

  function automatic logic [31:0] word_of(input int i);
    logic [31:0] w;
    for (int n = 0; n < 4; n++) w[8*n +: 8] = lane_byte(n, i);
    return w;
  endfunction

  task automatic setup(input int s0, s1, s2, s3, input int l0, l1, l2, l3,
                       input logic [7:0] sd, input int dup, input int rst, input int err,
                       input bit expw);
    sync_at = '{s0, s1, s2, s3};
    len_at  = '{l0, l1, l2, l3};
    seed = sd; dup_at = dup; rst_at = rst; err_at = err; expect_words = expw;
    q.delete();
  endtask

  // Drives relative cycle r; the word whose last lane byte lands now is due two cycles later.
  task automatic step(input int r);
    logic [31:0] d;
    logic [3:0]  s, v;
    exp_t        e;
    int          last, mlen;
    @(posedge clk); #1;
    if (rst_at >= 0 && r == rst_at + 1) q.delete();
    d = '0; s = '0; v = '0; last = 0; mlen = 1000;
    for (int n = 0; n < 4; n++) begin
      if (sync_at[n] >= 0) begin
        if (r == sync_at[n] || (n == 0 && r == dup_at)) s[n] = 1'b1;
        if (r >= sync_at[n] && r <= sync_at[n] + len_at[n]) begin
          v[n] = 1'b1;
          d[8*n +: 8] = (r == sync_at[n]) ? 8'hB8 : lane_byte(n, r - sync_at[n] - 1);
        end
        if (sync_at[n] > last) last = sync_at[n];
        if (len_at[n] < mlen) mlen = len_at[n];
      end
    end
    if (expect_words && (rst_at < 0 || r <= rst_at) && r > last && (r - last - 1) < mlen) begin
      e.word = word_of(r - last - 1);
      e.cyc  = r + 2;
      q.push_back(e);
    end
    hs_rx_data_i = d; hs_rx_data_sync_i = s; hs_rx_valid_i = v;
    sync_rst_i = (rst_at >= 0 && r == rst_at);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    hs_rx_data_sync_i = '1; hs_rx_valid_i = '1; hs_rx_data_i = 32'hDEADBEEF;
    @(posedge clk); #1;
    sync_rst_i = 1'b0; hs_rx_data_sync_i = '0; hs_rx_valid_i = '0; hs_rx_data_i = '0;
    @(negedge clk);
    checks++; if (aligned_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b required 0", aligned_valid_o); end
    checks++; if (aligned_sot_o !== 1'b0) begin errors++; $display("FAIL rst_sot got %b required 0", aligned_sot_o); end
    checks++; if (skew_err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b required 0", skew_err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy_o); end
    checks++; if (aligned_data_o !== 32'h0) begin errors++; $display("FAIL rst_data got %h required 0", aligned_data_o); end
  endtask

  task automatic test_zero_skew();
    exp_t e;
    int   nw = 0;
    setup(10, 10, 10, 10, 16, 16, 16, 16, 8'h00, -1, -1, -1, 1'b1);
    for (int r = 0; r < 36; r++) begin
      step(r);
      if (aligned_valid_o) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL zs_word r=%0d got %h required none", r, aligned_data_o); end
        else begin
          e = q.pop_front();
          if (aligned_data_o !== e.word || r != e.cyc || aligned_sot_o !== (nw == 0)) begin
            errors++; $display("FAIL zs_word got %h@%0d sot=%b required %h@%0d sot=%b", aligned_data_o, r, aligned_sot_o, e.word, e.cyc, nw == 0);
          end
        end
        nw++;
      end
      checks++;
      if ({skew_err_o, aligned_sot_o & ~aligned_valid_o} !== {r == err_at, 1'b0}) begin
        errors++; $display("FAIL zs_err r=%0d got err=%b sot=%b required no pulse", r, skew_err_o, aligned_sot_o);
      end
      if (r == 9 || r == 11 || r == 31) begin
        checks++; if (busy_o !== (r == 11)) begin errors++; $display("FAIL zs_busy r=%0d got %b required %b", r, busy_o, r == 11); end
      end
    end
    checks++; if (nw != 16 || q.size() != 0) begin errors++; $display("FAIL zs_count got %0d words (%0d left) required 16 (0)", nw, q.size()); end
    checks++; if (aligned_data_o !== 32'h3F3E3D3C) begin errors++; $display("FAIL zs_hold got %h required 3f3e3d3c", aligned_data_o); end
  endtask

  task automatic test_skew3();
    exp_t e;
    int   nw = 0;
    setup(10, 11, 12, 13, 16, 16, 16, 16, 8'h40, -1, -1, -1, 1'b1);
    for (int r = 0; r < 36; r++) begin
      step(r);
      if (aligned_valid_o) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL sk3_word r=%0d got %h required none", r, aligned_data_o); end
        else begin
          e = q.pop_front();
          if (aligned_data_o !== e.word || r != e.cyc || aligned_sot_o !== (nw == 0)) begin
            errors++; $display("FAIL sk3_word got %h@%0d sot=%b required %h@%0d sot=%b", aligned_data_o, r, aligned_sot_o, e.word, e.cyc, nw == 0);
          end
        end
        nw++;
      end
      checks++;
      if ({skew_err_o, aligned_sot_o & ~aligned_valid_o} !== {r == err_at, 1'b0}) begin
        errors++; $display("FAIL sk3_err r=%0d got err=%b sot=%b required no pulse", r, skew_err_o, aligned_sot_o);
      end
    end
    checks++; if (nw != 16 || q.size() != 0) begin errors++; $display("FAIL sk3_count got %0d words (%0d left) required 16 (0)", nw, q.size()); end
  endtask

  task automatic test_skew_timeout();
    setup(10, 10, 10, 14, 8, 8, 8, 8, 8'h00, -1, -1, 14, 1'b0);
    for (int r = 0; r < 26; r++) begin
      step(r);
      checks++;
      if ({skew_err_o, aligned_valid_o} !== {r == err_at, 1'b0}) begin
        errors++; $display("FAIL to_err r=%0d got err=%b valid=%b required err=%b valid=0", r, skew_err_o, aligned_valid_o, r == err_at);
      end
      if (r >= 14 && r <= 16) begin
        checks++; if (busy_o !== (r != 16)) begin errors++; $display("FAIL to_busy r=%0d got %b required %b", r, busy_o, r != 16); end
      end
    end
  endtask

  task automatic test_dup_sync();
    setup(10, -1, -1, -1, 8, 0, 0, 0, 8'h00, 11, -1, 11, 1'b0);
    for (int r = 0; r < 20; r++) begin
      step(r);
      checks++;
      if ({skew_err_o, aligned_valid_o} !== {r == err_at, 1'b0}) begin
        errors++; $display("FAIL dup_err r=%0d got err=%b valid=%b required err=%b valid=0", r, skew_err_o, aligned_valid_o, r == err_at);
      end
      if (r >= 11 && r <= 13) begin
        checks++; if (busy_o !== (r != 13)) begin errors++; $display("FAIL dup_busy r=%0d got %b required %b", r, busy_o, r != 13); end
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    exp_t e;
    int   nw = 0;
    setup(10, 10, 10, 10, 10, 10, 10, 10, 8'h80, -1, 20, -1, 1'b1);
    for (int r = 0; r < 25; r++) begin
      step(r);
      if (aligned_valid_o) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL mrst_word r=%0d got %h required none", r, aligned_data_o); end
        else begin
          e = q.pop_front();
          if (aligned_data_o !== e.word || r != e.cyc) begin errors++; $display("FAIL mrst_word got %h@%0d required %h@%0d", aligned_data_o, r, e.word, e.cyc); end
        end
        nw++;
      end
      checks++; if (skew_err_o !== 1'b0) begin errors++; $display("FAIL mrst_err r=%0d got 1 required 0", r); end
      if (r == 21) begin
        checks++;
        if ({aligned_valid_o, aligned_sot_o, busy_o, aligned_data_o} !== 35'h0) begin
          errors++; $display("FAIL mrst_zero got v=%b sot=%b busy=%b data=%h required all 0", aligned_valid_o, aligned_sot_o, busy_o, aligned_data_o);
        end
      end
    end
    checks++; if (nw != 8) begin errors++; $display("FAIL mrst_count got %0d words required 8", nw); end
    nw = 0;
    setup(2, 3, 2, 3, 6, 6, 6, 6, 8'hC0, -1, -1, -1, 1'b1);
    for (int r = 0; r < 16; r++) begin
      step(r);
      if (aligned_valid_o) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL mrst2_word r=%0d got %h required none", r, aligned_data_o); end
        else begin
          e = q.pop_front();
          if (aligned_data_o !== e.word || r != e.cyc || aligned_sot_o !== (nw == 0)) begin
            errors++; $display("FAIL mrst2_word got %h@%0d sot=%b required %h@%0d sot=%b", aligned_data_o, r, aligned_sot_o, e.word, e.cyc, nw == 0);
          end
        end
        nw++;
      end
      checks++; if (skew_err_o !== 1'b0) begin errors++; $display("FAIL mrst2_err r=%0d got 1 required 0", r); end
    end
    checks++; if (nw != 6 || q.size() != 0) begin errors++; $display("FAIL mrst2_count got %0d words (%0d left) required 6 (0)", nw, q.size()); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   nw, nsot;
    for (int b = 0; b < 2; b++) begin
      nw = 0; nsot = 0;
      if (b == 0) setup(10, 10, 10, 10, 16, 18, 16, 16, 8'h10, -1, -1, -1, 1'b1);
      else        setup(1, 1, 3, 1, 12, 12, 12, 12, 8'h55, -1, -1, -1, 1'b1);
      for (int r = 0; r < ((b == 0) ? 30 : 22); r++) begin
        step(r);
        if (aligned_sot_o) nsot++;
        if (aligned_valid_o) begin
          checks++;
          if (q.size() == 0) begin errors++; $display("FAIL b2b%0d_word r=%0d got %h required none", b, r, aligned_data_o); end
          else begin
            e = q.pop_front();
            if (aligned_data_o !== e.word || r != e.cyc || aligned_sot_o !== (nw == 0)) begin
              errors++; $display("FAIL b2b%0d_word got %h@%0d sot=%b required %h@%0d sot=%b", b, aligned_data_o, r, aligned_sot_o, e.word, e.cyc, nw == 0);
            end
          end
          nw++;
        end
        checks++; if (skew_err_o !== 1'b0) begin errors++; $display("FAIL b2b%0d_err r=%0d got 1 required 0", b, r); end
      end
      checks++;
      if (nsot != 1 || nw != ((b == 0) ? 16 : 12) || q.size() != 0) begin
        errors++; $display("FAIL b2b%0d_count got sot=%0d words=%0d left=%0d required sot=1 words=%0d left=0", b, nsot, nw, q.size(), (b == 0) ? 16 : 12);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_skew();
    test_skew3();
    test_skew_timeout();
    test_dup_sync();
    test_reset_mid_stream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0t, required completion", $time);
    $fatal(1, "timeout");
  end
endmodule
